// File: rtl/int_mul_seq_pkg.sv
// int_mul_pkg: shared state encoding, step-count helper and parameter legality check for int_mul_seq.
package int_mul_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX} mul_state_t;

    function automatic int mul_steps(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic bit mul_cfg_ok(input int width, input int bpc);
        return width >= 4 && width % 2 == 0 && (bpc == 1 || bpc == 2 || bpc == 4) && width % bpc == 0;
    endfunction
endpackage

// File: rtl/int_mul_seq_if.sv
// int_mul_seq_if: start/busy/done handshake and operand/product bus between controller and multiplier.
interface int_mul_seq_if #(parameter int WIDTH = 16);
    logic               start;
    logic               sign;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] OUT;

    modport master(output start, sign, A, B, input busy, done, OUT);
    modport slave(input start, sign, A, B, output busy, done, OUT);
endinterface

// File: rtl/int_mul_seq_abs.sv
// int_mul_abs: combinational conditional two's-complement negate.
module int_mul_abs #(parameter int WIDTH = 16) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);
    assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/int_mul_seq.sv
// int_mul_seq: sequential signed/unsigned multiplier retiring BITS_PER_CYCLE multiplier bits per cycle.
// Optional INT_MUL_EARLY_TERM_EN ends CALC once the remaining multiplier bits are all zero.
module int_mul_seq
    import int_mul_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic         clk,
    input logic         rst,
    int_mul_seq_if.slave bus
);
    localparam int N  = mul_steps(WIDTH, BITS_PER_CYCLE);
    localparam int K  = BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    if (!mul_cfg_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
        $error("int_mul_seq: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    mul_state_t         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_out;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic               r_done;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH+K-1:0] w_pp;
    logic [2*WIDTH-1:0] w_part;
    logic               w_last;

    int_mul_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_val(bus.A), .i_neg(bus.sign & bus.A[WIDTH-1]), .o_val(w_abs_a)
    );
    int_mul_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_val(bus.B), .i_neg(bus.sign & bus.B[WIDTH-1]), .o_val(w_abs_b)
    );
    int_mul_abs #(.WIDTH(2 * WIDTH)) u_abs_out (
        .i_val(r_acc), .i_neg(r_neg), .o_val(w_res)
    );

    // partial product of the low K multiplier bits, placed at the current digit position
    assign w_pp   = {{K{1'b0}}, r_mcand} * {{WIDTH{1'b0}}, r_mplier[K-1:0]};
    assign w_part = {{(WIDTH-K){1'b0}}, w_pp} << ((N - int'(r_cnt)) * K);

`ifdef INT_MUL_EARLY_TERM_EN
    assign w_last = r_cnt == CW'(1) || (r_mplier >> K) == '0;
`else
    assign w_last = r_cnt == CW'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_out    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_mcand  <= w_abs_a;
                    r_mplier <= w_abs_b;
                    r_neg    <= bus.sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    r_acc    <= '0;
                    r_cnt    <= CW'(N);
                    r_state  <= CALC;
                end
                CALC: begin
                    r_acc    <= r_acc + w_part;
                    r_mplier <= r_mplier >> K;
                    r_cnt    <= r_cnt - CW'(1);
                    r_state  <= w_last ? FIX : CALC;
                end
                FIX: begin
                    r_out   <= w_res;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // the result-publishing cycle still counts as busy
    assign bus.busy = r_state != IDLE || r_done;
    assign bus.done = r_done;
    assign bus.OUT  = r_out;
endmodule
